// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo -- parametrised single-clock FIFO (prefetch / byte / stage queue)
//
// Any DEPTH >= 2, including non-power-of-two; every entry is usable. The
// occupancy is a dedicated counter, so full/empty never depend on pointer
// tricks. Read port is either registered (FWFT=0) or fall-through (FWFT=1).
//
// Optional feature: define SYNC_FIFO_ERROR_FLAGS_EN to build the sticky
// overflow/underflow flag registers; otherwise both outputs are tied to 0.
//
// Ports:
//   clock         rising-edge clock
//   reset         synchronous active-low reset
//   flush         synchronous discard of all queued words
//   write_enable  push request,  write_data push word
//   read_enable   pop request,   read_data  pop word (timing per FWFT)
//   is_empty / is_full / almost_empty / almost_full  status from length
//   length        exact occupancy 0..DEPTH
//   overflow      sticky: push attempted while full
//   underflow     sticky: pop attempted while empty
// ---------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH_DATA   = 8,
   parameter int DEPTH        = 6,
   parameter int FWFT         = 0,
   parameter int ALMOST_FULL  = DEPTH - 1,
   parameter int ALMOST_EMPTY = 1
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         write_enable,
   input  logic [WIDTH_DATA-1:0]        write_data,
   input  logic                         read_enable,
   output logic [WIDTH_DATA-1:0]        read_data,
   output logic                         is_empty,
   output logic                         is_full,
   output logic                         almost_empty,
   output logic                         almost_full,
   output logic [$clog2(DEPTH+1)-1:0]   length,
   output logic                         overflow,
   output logic                         underflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LEN_W = $clog2(DEPTH + 1);

   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(DEPTH);
   localparam logic [LEN_W-1:0] LEN_AF   = LEN_W'(ALMOST_FULL);
   localparam logic [LEN_W-1:0] LEN_AE   = LEN_W'(ALMOST_EMPTY);

   logic [WIDTH_DATA-1:0] ram [DEPTH];
   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic [LEN_W-1:0]      len_q;
   logic                  push_ok, pop_ok;

   // Explicit wrap so non-power-of-two depths step DEPTH-1 -> 0.
   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   assign length       = len_q;
   assign is_empty     = (len_q == '0);
   assign is_full      = (len_q == LEN_FULL);
   assign almost_empty = (len_q <= LEN_AE);
   assign almost_full  = (len_q >= LEN_AF);

   // Acceptance is judged on the pre-edge state only: no full-with-pop or
   // empty-with-push bypass. Reset and flush suppress both sides, which also
   // keeps the RAM and the read register untouched on those edges.
   assign push_ok = reset && !flush && write_enable && !is_full;
   assign pop_ok  = reset && !flush && read_enable  && !is_empty;

   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         len_q  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         len_q  <= '0;
      end else begin
         if (push_ok) wr_ptr <= ptr_next(wr_ptr);
         if (pop_ok)  rd_ptr <= ptr_next(rd_ptr);
         case ({push_ok, pop_ok})
            2'b10:   len_q <= len_q + LEN_W'(1);
            2'b01:   len_q <= len_q - LEN_W'(1);
            default: len_q <= len_q;
         endcase
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clock) begin
      if (push_ok) ram[wr_ptr] <= write_data;
   end

   generate
      if (FWFT != 0) begin : g_fwft
         // Head word is presented directly; meaningless while empty.
         assign read_data = ram[rd_ptr];
      end else begin : g_reg
         logic [WIDTH_DATA-1:0] rd_q;
         always_ff @(posedge clock) begin
            if (!reset)      rd_q <= '0;
            else if (pop_ok) rd_q <= ram[rd_ptr];
         end
         assign read_data = rd_q;
      end
   endgenerate

`ifdef SYNC_FIFO_ERROR_FLAGS_EN
   logic ovf_q, unf_q;
   // A rejected request during flush is not an error: the queue is being
   // discarded anyway.
   always_ff @(posedge clock) begin
      if (!reset) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else if (!flush) begin
         if (write_enable && is_full)  ovf_q <= 1'b1;
         if (read_enable  && is_empty) unf_q <= 1'b1;
      end
   end
   assign overflow  = ovf_q;
   assign underflow = unf_q;
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Parametrised single-clock FIFO. It is the next-generation queue primitive for the core: bus-unit prefetch queue, instruction byte queue and inter-stage buffers.
- Any DEPTH ≥ 2 (non-power-of-two allowed); all DEPTH entries are usable.
- Exact occupancy count.
- Selectable standard or first-word-fall-through (FWFT) read mode.
- Programmable almost-full / almost-empty thresholds.
- Synchronous flush, used to discard the prefetch queue on control transfer.

Parameters:
WIDTH_DATA, 8, data word width in bits (≥1)
DEPTH, 6, number of storage entries (≥2, need not be power of two)
FWFT, 0, 0 = registered read data one cycle after pop; 1 = head word visible combinationally
ALMOST_FULL, DEPTH-1, almost_full asserted when length ≥ this value (1..DEPTH)
ALMOST_EMPTY, 1, almost_empty asserted when length ≤ this value (0..DEPTH-1)

Ports:
clock  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset; sampled on rising clock edge
flush  input  1  synchronous queue discard
write_enable  input  1  push request
write_data  input  WIDTH_DATA  push data
read_enable  input  1  pop request
read_data  output  WIDTH_DATA  pop data (timing per FWFT)
is_empty  output  1  length == 0
is_full  output  1  length == DEPTH
almost_empty  output  1  length ≤ ALMOST_EMPTY
almost_full  output  1  length ≥ ALMOST_FULL
length  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH exactly
overflow  output  1  sticky: push attempted while full (see Optional Feature)
underflow  output  1  sticky: pop attempted while empty (see Optional Feature)

Behaviour:
- Pointers are $clog2(DEPTH) bits wide. Each increments modulo DEPTH: DEPTH-1 wraps to 0. No power-of-two masking.
- length is a registered counter, not derived from the pointers. is_empty, is_full, almost_* are combinational from length.
- Push accepted iff write_enable && !is_full.
  - Accepted push writes ram[wr_ptr] and advances wr_ptr.
  - Push while full: rejected; no state change except overflow.
- Pop accepted iff read_enable && !is_empty.
  - Accepted pop advances rd_ptr.
  - Pop while empty: rejected; no state change except underflow.
- Simultaneous accepted push and pop: both pointers advance; length unchanged.
- When full, write is rejected even if a pop is accepted in the same cycle. When empty, a pop is rejected even if a push is accepted in the same cycle. There is no bypass path.
- Read timing, FWFT=0:
  - read_data is a register loaded with ram[rd_ptr] on an accepted pop; valid the cycle after.
  - Holds its value otherwise.
- Read timing, FWFT=1:
  - read_data = ram[rd_ptr] combinationally, valid whenever !is_empty.
  - Value when empty is don't-care.
  - read_enable acknowledges and removes the head word.
- Push-to-visible latency: a word pushed at edge N is poppable from cycle N+1. With FWFT=1 it appears on read_data in cycle N+1.
- flush=1:
  - At the next edge, rd_ptr, wr_ptr and length go to 0.
  - Overrides any push or pop in the same cycle.
  - RAM contents and read_data register are untouched.
  - overflow and underflow are unaffected.
- reset=0 at an edge:
  - rd_ptr, wr_ptr, length → 0; read_data register → 0; overflow, underflow → 0.
  - Resulting outputs: is_empty=1, is_full=0, almost_empty=1, almost_full=0.
  - Reset overrides flush, push and pop. An in-flight sequence is simply discarded.
- RAM is not reset. No read-during-write hazard exists: read and write addresses are never equal while a valid pop and a push are both accepted, except when length is 0, where pops are rejected.

Optional Feature:
Macro: SYNC_FIFO_ERROR_FLAGS_EN.
- Defined:
  - overflow sets at the edge where write_enable && is_full && flush==0.
  - underflow sets at the edge where read_enable && is_empty && flush==0.
  - Both stay set until reset.
- Not defined: overflow and underflow are tied to 0 and no flag registers are built. Ports remain present in both builds.

Test Plan:
- DEPTH=5, FWFT=0: push 0x11..0x15 → is_full=1, length=5, almost_full=1. Sixth push of 0x99 rejected and length stays 5 (with SYNC_FIFO_ERROR_FLAGS_EN: overflow=1). Pop ×5 → read_data 0x11..0x15, each one cycle after its pop; is_empty=1.
- DEPTH=5 wrap: push 3, pop 3, then push 0xA0..0xA4 → both pointers wrap past 4→0. Pops return 0xA0..0xA4 in order; length sequence goes 5,4,3,2,1,0.
- Simultaneous push+pop at length=2 for 10 cycles → length stays 2, data order preserved. At length=5 with both enables → only the pop is accepted, length becomes 4. At length=0 with both enables → only the push is accepted, length becomes 1.
- FWFT=1, DEPTH=4: push 0x5A at edge N → read_data=0x5A and is_empty=0 in cycle N+1 with no read_enable. Pop → next head appears the same cycle the pointer advances.
- Flush at length=3 with simultaneous push and pop → length=0 and is_empty=1 next cycle. Next push 0x42 then pop returns 0x42. Pop while empty (with SYNC_FIFO_ERROR_FLAGS_EN) → underflow=1; only reset clears it.
- reset=0 asserted mid-stream at length=4 for one edge → length=0, read_data=0, all flags at their reset values. Ports are ignored during reset; normal operation resumes the cycle after reset returns to 1.
